// File: rtl/router_output_allocator.sv
// Per-output switch allocator: round-robin head-flit arbitration, wormhole lock until tail, downstream credit gating.
// Grant is combinational (0-cycle), state updates at next clk; optional counters under ROUTER_ALLOC_STATS_EN.
module router_output_allocator #(
  parameter int NUM_INPUTS        = 5,
  parameter int FLIT_BUFFER_DEPTH = 4,
  parameter int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1),
  parameter int IDX_WIDTH         = $clog2(NUM_INPUTS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_INPUTS-1:0]   req_in,
  input  logic [NUM_INPUTS-1:0]   tail_in,
  input  logic [NUM_INPUTS-1:0]   turn_mask,
  input  logic                    credit_in,
  output logic [NUM_INPUTS-1:0]   grant_out,
  output logic                    send_out,
  output logic                    locked,
  output logic [IDX_WIDTH-1:0]    owner,
  output logic [CREDIT_WIDTH-1:0] credits,
  output logic                    credit_err
`ifdef ROUTER_ALLOC_STATS_EN
  ,
  output logic [31:0]             stat_flits,
  output logic [31:0]             stat_stall
`endif
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
  localparam logic [IDX_WIDTH-1:0]    LAST_IDX   = IDX_WIDTH'(NUM_INPUTS - 1);

  state_t                 state;
  logic [IDX_WIDTH-1:0]   rr_ptr;
  logic [NUM_INPUTS-1:0]  elig;
  logic [IDX_WIDTH-1:0]   winner;
  logic                   found;
  logic [IDX_WIDTH:0]     cand;
  logic                   has_credit;
  logic                   winner_tail;

  function automatic logic [IDX_WIDTH-1:0] next_idx(input logic [IDX_WIDTH-1:0] w);
    next_idx = (w == LAST_IDX) ? '0 : w + 1'b1;
  endfunction

  assign elig       = req_in & ~turn_mask;
  assign has_credit = (credits != '0);

  // Locked output ignores turn_mask so a mid-packet mask change cannot strand a worm.
  always_comb begin
    grant_out = '0;
    winner    = '0;
    found     = 1'b0;
    cand      = '0;
    if (!rst && has_credit) begin
      if (state == LOCKED) begin
        winner = owner;
        if (req_in[owner]) begin
          grant_out[owner] = 1'b1;
        end
      end else begin
        for (int k = 0; k < NUM_INPUTS; k++) begin
          cand = {1'b0, rr_ptr} + (IDX_WIDTH + 1)'(k);
          if (cand >= (IDX_WIDTH + 1)'(NUM_INPUTS)) begin
            cand = cand - (IDX_WIDTH + 1)'(NUM_INPUTS);
          end
          if (!found && elig[cand[IDX_WIDTH-1:0]]) begin
            found     = 1'b1;
            winner    = cand[IDX_WIDTH-1:0];
            grant_out[cand[IDX_WIDTH-1:0]] = 1'b1;
          end
        end
      end
    end
  end

  assign send_out    = |grant_out;
  assign winner_tail = tail_in[winner];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      credits    <= CREDIT_MAX;
      locked     <= 1'b0;
      owner      <= '0;
      credit_err <= 1'b0;
    end else begin
      case ({send_out, credit_in})
        2'b10: credits <= credits - 1'b1;
        2'b01: begin
          if (credits == CREDIT_MAX) begin
            credit_err <= 1'b1;
          end else begin
            credits <= credits + 1'b1;
          end
        end
        default: credits <= credits;
      endcase

      case (state)
        IDLE: begin
          if (send_out) begin
            if (winner_tail) begin
              rr_ptr <= next_idx(winner);
            end else begin
              state  <= LOCKED;
              owner  <= winner;
              locked <= 1'b1;
            end
          end
        end
        LOCKED: begin
          // An upstream bubble simply leaves the lock in place.
          if (send_out && winner_tail) begin
            state  <= IDLE;
            locked <= 1'b0;
            rr_ptr <= next_idx(owner);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROUTER_ALLOC_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_flits <= '0;
      stat_stall <= '0;
    end else begin
      if (send_out && (stat_flits != '1)) begin
        stat_flits <= stat_flits + 32'd1;
      end
      if ((elig != '0) && !has_credit && (stat_stall != '1)) begin
        stat_stall <= stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_router_output_allocator.sv
// Directed-vector bench: the driver queues hand-computed expectations, a negedge monitor pops and compares.
module tb_router_output_allocator;

  logic       clk;
  logic       rst;
  logic [4:0] req_in, tail_in, turn_mask;
  logic       credit_in;
  logic [4:0] grant_out;
  logic       send_out, locked, credit_err;
  logic [2:0] owner;
  logic [2:0] credits;
`ifdef ROUTER_ALLOC_STATS_EN
  logic [31:0] stat_flits, stat_stall;
`endif

  router_output_allocator dut (
    .clk(clk), .rst(rst), .req_in(req_in), .tail_in(tail_in), .turn_mask(turn_mask),
    .credit_in(credit_in), .grant_out(grant_out), .send_out(send_out), .locked(locked),
    .owner(owner), .credits(credits), .credit_err(credit_err)
`ifdef ROUTER_ALLOC_STATS_EN
    , .stat_flits(stat_flits), .stat_stall(stat_stall)
`endif
  );

  typedef struct packed {
    logic [4:0] grant;
    logic [2:0] cr;
    logic       lk;
    logic [2:0] own;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  // Monitor: compares current outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (grant_out !== e.grant || send_out !== (|e.grant) || credits !== e.cr ||
            locked !== e.lk || credit_err !== e.err || (e.lk && owner !== e.own)) begin
          miscompares++;
          $display("FAIL vec%0d: got grant=%b send=%b credits=%0d locked=%b owner=%0d err=%b, want grant=%b send=%b credits=%0d locked=%b owner=%0d err=%b",
                   vectors, grant_out, send_out, credits, locked, owner, credit_err,
                   e.grant, |e.grant, e.cr, e.lk, e.own, e.err);
        end
      end
    end
  end

  task automatic apply(input logic r, input logic [4:0] rq, input logic [4:0] tl,
                       input logic [4:0] mk, input logic ci, input logic [4:0] g,
                       input logic [2:0] cr, input logic lk, input logic [2:0] own,
                       input logic err);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; req_in = rq; tail_in = tl; turn_mask = mk; credit_in = ci;
    e.grant = g; e.cr = cr; e.lk = lk; e.own = own; e.err = err;
    q.push_back(e);
  endtask

  initial begin
    rst = 0; req_in = 0; tail_in = 0; turn_mask = 0; credit_in = 0;
    #1 rst = 1;
    //     rst req      tail     mask     ci grant    cr lk own err
    apply(1, 5'b00110, 5'b00110, 5'b00000, 0, 5'b00000, 4, 0, 0, 0);
    // Single-flit packets alternate until credits run out.
    apply(0, 5'b00110, 5'b00110, 5'b00000, 0, 5'b00010, 4, 0, 0, 0);
    apply(0, 5'b00110, 5'b00110, 5'b00000, 0, 5'b00100, 3, 0, 0, 0);
    apply(0, 5'b00110, 5'b00110, 5'b00000, 0, 5'b00010, 2, 0, 0, 0);
    apply(0, 5'b00110, 5'b00110, 5'b00000, 0, 5'b00100, 1, 0, 0, 0);
    apply(0, 5'b00110, 5'b00110, 5'b00000, 0, 5'b00000, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      apply(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 3'(i), 0, 0, 0);
    // Wormhole: input 3 owns the output for 3 flits with a bubble; input 1 waits.
    apply(0, 5'b01010, 5'b00000, 5'b00000, 0, 5'b01000, 4, 0, 0, 0);
    apply(0, 5'b01010, 5'b00000, 5'b00000, 0, 5'b01000, 3, 1, 3, 0);
    apply(0, 5'b00010, 5'b00010, 5'b00000, 0, 5'b00000, 2, 1, 3, 0);
    apply(0, 5'b01010, 5'b01000, 5'b00000, 0, 5'b01000, 2, 1, 3, 0);
    apply(0, 5'b00010, 5'b00010, 5'b00000, 0, 5'b00010, 1, 0, 0, 0);
    // Credit exhaustion and recovery.
    apply(0, 5'b00010, 5'b00010, 5'b00000, 0, 5'b00000, 0, 0, 0, 0);
    apply(0, 5'b00010, 5'b00010, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);
    apply(0, 5'b00010, 5'b00010, 5'b00000, 0, 5'b00010, 1, 0, 0, 0);
    apply(0, 5'b00010, 5'b00010, 5'b00000, 0, 5'b00000, 0, 0, 0, 0);
    apply(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);
    apply(0, 5'b00010, 5'b00010, 5'b00000, 1, 5'b00010, 1, 0, 0, 0);
    apply(0, 5'b00010, 5'b00010, 5'b00000, 0, 5'b00010, 1, 0, 0, 0);
    apply(0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      apply(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 3'(i), 0, 0, 0);
    // Turn mask blocks new grants but not an established lock.
    apply(0, 5'b00001, 5'b00001, 5'b00001, 0, 5'b00000, 4, 0, 0, 0);
    apply(0, 5'b00001, 5'b00000, 5'b00000, 0, 5'b00001, 4, 0, 0, 0);
    apply(0, 5'b00001, 5'b00000, 5'b00001, 0, 5'b00001, 3, 1, 0, 0);
    apply(0, 5'b00001, 5'b00001, 5'b00001, 0, 5'b00001, 2, 1, 0, 0);
    apply(0, 5'b00001, 5'b00001, 5'b00001, 0, 5'b00000, 1, 0, 0, 0);
    apply(0, 5'b00011, 5'b00011, 5'b00000, 0, 5'b00010, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      apply(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 3'(i), 0, 0, 0);
    // Credit overflow is sticky.
    apply(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 4, 0, 0, 0);
    apply(0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 4, 0, 0, 1);
    apply(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 4, 0, 0, 1);
    apply(0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 4, 0, 0, 1);
    // Reset while locked with one credit left.
    apply(0, 5'b10000, 5'b00000, 5'b00000, 0, 5'b10000, 4, 0, 0, 1);
    apply(0, 5'b10000, 5'b00000, 5'b00000, 0, 5'b10000, 3, 1, 4, 1);
    apply(0, 5'b10000, 5'b00000, 5'b00000, 0, 5'b10000, 2, 1, 4, 1);
    apply(0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 1, 1, 4, 1);
    apply(1, 5'b10000, 5'b00000, 5'b00000, 0, 5'b00000, 4, 0, 0, 0);
    apply(0, 5'b00110, 5'b00110, 5'b00000, 0, 5'b00010, 4, 0, 0, 0);
    // Traffic for the statistics counters: 10 sends, 3 stalls since reset.
    apply(0, 5'b00110, 5'b00110, 5'b00000, 0, 5'b00100, 3, 0, 0, 0);
    apply(0, 5'b00110, 5'b00110, 5'b00000, 0, 5'b00010, 2, 0, 0, 0);
    apply(0, 5'b00110, 5'b00110, 5'b00000, 0, 5'b00100, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      apply(0, 5'b00110, 5'b00110, 5'b00000, 0, 5'b00000, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      apply(0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 3'(i), 0, 0, 0);
    for (int i = 0; i < 6; i++)
      apply(0, 5'b00110, 5'b00110, 5'b00000, 1, (i % 2 == 0) ? 5'b00010 : 5'b00100, 4, 0, 0, 0);
    apply(0, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 4, 0, 0, 0);
    @(negedge clk);
    #1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: %0d expectations left, want 0", q.size());
    end
`ifdef ROUTER_ALLOC_STATS_EN
    vectors++;
    if (stat_flits !== 32'd10 || stat_stall !== 32'd3) begin
      miscompares++;
      $display("FAIL stats: got flits=%0d stall=%0d, want flits=10 stall=3", stat_flits, stat_stall);
    end
`endif
    done = 1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
